mux_rr_arbiter: RTL and testbench

Round-robin arbiter sharing one 48-bit selection path among four requesters inside the DSP48A1 slice datapath. It grants one requester at a time for a burst of beats and drives the 2-bit `sel` that steers the 4:1 48-bit operand mux. It also registers the selected word into a single-entry output stage with valid/ready backpressure. A programmable beat limit forces re-arbitration so that no requester can starve the others.

---
 rtl/mux_rr_arbiter_if.sv | 26 ++
 rtl/mux_rr_arbiter.sv | 127 ++++++++++++
 tb/tb_mux_rr_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/mux_rr_arbiter_if.sv
// Handshake bundle between four requesters, the round-robin arbiter and the downstream consumer.
// The arbiter uses the slave view and the traffic source/sink uses the master view.
interface mux_rr_arbiter_if #(
    parameter int WIDTH = 48
);
    logic [3:0]         req_valid;
    logic [3:0]         req_last;
    logic [4*WIDTH-1:0] req_data;
    logic [3:0]         req_ready;
    logic [1:0]         sel;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic               out_last;
    logic               out_ready;
    logic               busy;

    modport slave (
        input  req_valid, req_last, req_data, out_ready,
        output req_ready, sel, out_valid, out_data, out_last, busy
    );

    modport master (
        output req_valid, req_last, req_data, out_ready,
        input  req_ready, sel, out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin 4:1 burst arbiter: 1 idle arbitration cycle per grant, then 1-cycle registered data path.
// Backpressure: req_ready of the granted requester follows (!out_valid || out_ready); the output stage holds while stalled.
module mux_rr_arbiter #(
    parameter int WIDTH     = 48,
    parameter int MAX_BURST = 16
) (
    input logic             clk_i,
    input logic             rst_ni,
    mux_rr_arbiter_if.slave bus
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    localparam bit         LIMIT_ON = (MAX_BURST != 0);
    localparam logic [7:0] CNT_LAST = LIMIT_ON ? 8'(MAX_BURST - 1) : 8'd0;

    state_t             state_q, state_d;
    logic [1:0]         grant_q, grant_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               out_last_q, out_last_d;

    logic               win_vld;
    logic [1:0]         win_idx;
    logic               stage_free;
    logic               xfer;
    logic               beat_last;
    logic [WIDTH-1:0]   grant_dat;

    // Scan from ptr upwards; descending loop lets the closest requester overwrite farther ones.
    always_comb begin
        win_vld = 1'b0;
        win_idx = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            if (bus.req_valid[ptr_q + 2'(k)]) begin
                win_vld = 1'b1;
                win_idx = ptr_q + 2'(k);
            end
        end
    end

    always_comb begin
        grant_dat = '0;
        for (int i = 0; i < 4; i++) begin
            if (grant_q == 2'(i)) begin
                grant_dat = bus.req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign stage_free = !out_valid_q || bus.out_ready;
    assign xfer       = (state_q == ST_BURST) && stage_free && bus.req_valid[grant_q];
    assign beat_last  = bus.req_last[grant_q] || (LIMIT_ON && (cnt_q == CNT_LAST));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    state_d = ST_BURST;
                    grant_d = win_idx;
                    cnt_d   = 8'd0;
                end
            end
            ST_BURST: begin
                if (xfer) begin
                    cnt_d = cnt_q + 8'd1;
                    // A forced end also lands here, so the cut-off requester drops to lowest priority.
                    if (beat_last) begin
                        state_d = ST_IDLE;
                        ptr_d   = grant_q + 2'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_dat;
            out_last_d  = beat_last;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            grant_q     <= 2'd0;
            ptr_q       <= 2'd0;
            cnt_q       <= 8'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign bus.req_ready = ((state_q == ST_BURST) && stage_free) ? (4'b0001 << grant_q) : 4'b0000;
    assign bus.sel       = grant_q;
    assign bus.busy      = (state_q == ST_BURST);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter with MAX_BURST=4; inputs change 2 time units after each rising edge.
module tb_mux_rr_arbiter;
    localparam int WIDTH = 48;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_err = 0;

    mux_rr_arbiter_if #(.WIDTH(WIDTH)) bus ();

    mux_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(4)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_dat(input int i, input logic [WIDTH-1:0] v);
        bus.req_data[i*WIDTH +: WIDTH] = v;
    endtask

    task automatic chk_out(input string tag, input logic vld, input logic [WIDTH-1:0] dat, input logic lst);
        chk({tag, "_vld"},  64'(bus.out_valid), 64'(vld));
        chk({tag, "_dat"},  64'(bus.out_data),  64'(dat));
        chk({tag, "_last"}, 64'(bus.out_last),  64'(lst));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_sel"},  64'(bus.sel),       64'd0);
        chk({tag, "_busy"}, 64'(bus.busy),      64'd0);
        chk({tag, "_rdy"},  64'(bus.req_ready), 64'd0);
        chk_out(tag, 1'b0, '0, 1'b0);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        bus.out_ready = 1'b1;
        #1;
        chk_reset("rst");
        tick();
        tick();
        rst_n = 1'b1;

        // Single requester, three beats
        bus.req_valid = 4'b0100;
        set_dat(2, 48'hA);
        #1;
        chk("t1_rdy_before", 64'(bus.req_ready), 64'd0);
        tick();
        chk("t1_sel",  64'(bus.sel),       64'd2);
        chk("t1_busy", 64'(bus.busy),      64'd1);
        chk("t1_rdy",  64'(bus.req_ready), 64'b0100);
        chk("t1_nodat", 64'(bus.out_valid), 64'd0);
        tick();
        chk_out("t1_a", 1'b1, 48'hA, 1'b0);
        set_dat(2, 48'hB);
        tick();
        chk_out("t1_b", 1'b1, 48'hB, 1'b0);
        set_dat(2, 48'hC);
        bus.req_last = 4'b0100;
        tick();
        chk_out("t1_c", 1'b1, 48'hC, 1'b1);
        chk("t1_idle", 64'(bus.busy), 64'd0);
        bus.req_valid = 4'b1111;
        bus.req_last  = 4'b1111;
        set_dat(3, 48'hD);
        tick();
        chk("t1_ptr3", 64'(bus.sel), 64'd3);
        tick();
        chk_out("t1_d", 1'b1, 48'hD, 1'b1);
        bus.req_valid = 4'b0000;
        tick();
        chk("t1_drain", 64'(bus.out_valid), 64'd0);

        // Fairness from reset: single-beat bursts from all four
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) set_dat(i, 48'h100 + 48'(i));
        bus.req_valid = 4'b1111;
        bus.req_last  = 4'b1111;
        tick();
        rst_n = 1'b1;
        for (int g = 0; g < 5; g++) begin
            tick();
            chk("fair_sel",  64'(bus.sel),       64'(g % 4));
            chk("fair_busy", 64'(bus.busy),      64'd1);
            chk("fair_gap",  64'(bus.out_valid), 64'd0);
            tick();
            chk_out("fair_out", 1'b1, 48'h100 + 48'(g % 4), 1'b1);
            chk("fair_idle", 64'(bus.busy), 64'd0);
        end

        // Backpressure mid-burst
        bus.req_valid = 4'b0001;
        bus.req_last  = 4'b0000;
        set_dat(0, 48'h300);
        tick();
        chk("bp_sel", 64'(bus.sel), 64'd0);
        tick();
        chk_out("bp_0", 1'b1, 48'h300, 1'b0);
        bus.out_ready = 1'b0;
        set_dat(0, 48'h301);
        #1;
        chk("bp_rdy_low", 64'(bus.req_ready), 64'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_out("bp_hold", 1'b1, 48'h300, 1'b0);
            chk("bp_rdy_hold", 64'(bus.req_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_rdy_back", 64'(bus.req_ready), 64'b0001);
        tick();
        chk_out("bp_1", 1'b1, 48'h301, 1'b0);
        set_dat(0, 48'h302);
        bus.req_last = 4'b0001;
        tick();
        chk_out("bp_2", 1'b1, 48'h302, 1'b1);
        chk("bp_idle", 64'(bus.busy), 64'd0);
        bus.req_valid = 4'b0000;
        bus.req_last  = 4'b0000;
        tick();
        chk("bp_drain", 64'(bus.out_valid), 64'd0);

        // Forced end after 4 beats, requester 2 pending
        bus.req_valid = 4'b0110;
        bus.req_last  = 4'b0100;
        set_dat(1, 48'h401);
        set_dat(2, 48'h500);
        tick();
        chk("fe_sel1", 64'(bus.sel), 64'd1);
        for (int b = 1; b <= 4; b++) begin
            tick();
            chk_out("fe_beat", 1'b1, 48'h400 + 48'(b), (b == 4));
            set_dat(1, 48'h401 + 48'(b));
        end
        chk("fe_release", 64'(bus.busy), 64'd0);
        tick();
        chk("fe_sel2", 64'(bus.sel), 64'd2);
        tick();
        chk_out("fe_r2", 1'b1, 48'h500, 1'b1);
        bus.req_valid = 4'b0010;
        tick();
        chk("fe_sel1b", 64'(bus.sel), 64'd1);
        tick();
        chk_out("fe_b5", 1'b1, 48'h405, 1'b0);
        set_dat(1, 48'h406);
        bus.req_last = 4'b0010;
        tick();
        chk_out("fe_b6", 1'b1, 48'h406, 1'b1);
        bus.req_valid = 4'b0000;
        bus.req_last  = 4'b0000;

        // Bubbles: granted requester 2 pauses while requester 0 waits
        bus.req_valid = 4'b0101;
        bus.req_last  = 4'b0001;
        set_dat(2, 48'h600);
        set_dat(0, 48'h700);
        tick();
        chk("bub_sel", 64'(bus.sel), 64'd2);
        tick();
        chk_out("bub_0", 1'b1, 48'h600, 1'b0);
        bus.req_valid = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bub_hold_sel",  64'(bus.sel),       64'd2);
            chk("bub_hold_busy", 64'(bus.busy),      64'd1);
            chk("bub_hold_vld",  64'(bus.out_valid), 64'd0);
        end
        bus.req_valid = 4'b0101;
        set_dat(2, 48'h601);
        tick();
        chk_out("bub_1", 1'b1, 48'h601, 1'b0);
        set_dat(2, 48'h602);
        bus.req_last = 4'b0101;
        tick();
        chk_out("bub_2", 1'b1, 48'h602, 1'b1);
        tick();
        chk("bub_switch", 64'(bus.sel), 64'd0);
        tick();
        chk_out("bub_r0", 1'b1, 48'h700, 1'b1);
        bus.req_valid = 4'b0000;
        bus.req_last  = 4'b0000;

        // Reset mid-burst with a beat held in the output stage
        bus.req_valid = 4'b1000;
        set_dat(3, 48'h800);
        tick();
        chk("mr_sel", 64'(bus.sel), 64'd3);
        tick();
        chk_out("mr_pre", 1'b1, 48'h800, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_reset("mr_async");
        tick();
        bus.req_valid = 4'b1001;
        bus.req_last  = 4'b0001;
        set_dat(0, 48'h900);
        rst_n = 1'b1;
        tick();
        chk("mr_ptr0", 64'(bus.sel),  64'd0);
        chk("mr_busy", 64'(bus.busy), 64'd1);
        tick();
        chk_out("mr_r0", 1'b1, 48'h900, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
